// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: arbitrates start/score/stop message requests onto a
// byte-wide UART transmitter using a write strobe / busy handshake.
//
// Ports:
//   pclk, rst_n          clock, async active-low reset
//   req_start/score/stop one-cycle message requests (score_in with req_score)
//   tx_busy              transmitter busy shifting a byte
//   tx_wr, tx_data       byte write strobe and byte
//   sent_pulse, sent_id  message completion pulse and id (01/10/11)
//   arb_busy             work pending or in flight
//   tx_err               sticky handshake timeout
module uart_tx_arbiter #(
    parameter logic [7:0] CODE_START  = 8'h53,
    parameter logic [7:0] CODE_STOP   = 8'h45,
    parameter logic [7:0] CODE_SCORE  = 8'h50,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       req_start,
    input  logic       req_score,
    input  logic [7:0] score_in,
    input  logic       req_stop,
    input  logic       tx_busy,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       sent_pulse,
    output logic [1:0] sent_id,
    output logic       arb_busy,
    output logic       tx_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t        state, state_nx;
    logic          pend_start, pend_score, pend_stop;
    logic          clr_start, clr_score, clr_stop;
    logic [7:0]    score_buf;
    logic [7:0]    byte1, byte1_nx;
    logic          more, more_nx;
    logic [1:0]    msg_id, msg_id_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    data_nx;
    logic          sent_nx;
    logic [1:0]    sent_id_nx;
    logic          err_nx;

    assign tx_wr    = (state == ISSUE);
    assign arb_busy = pend_start | pend_score | pend_stop
                    | (state != IDLE);

    always_comb begin
        state_nx   = state;
        byte1_nx   = byte1;
        more_nx    = more;
        msg_id_nx  = msg_id;
        cnt_nx     = cnt;
        data_nx    = tx_data;
        sent_nx    = 1'b0;
        sent_id_nx = sent_id;
        err_nx     = tx_err;
        clr_start  = 1'b0;
        clr_score  = 1'b0;
        clr_stop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_busy && (pend_stop || pend_start || pend_score)) begin
                    state_nx = ISSUE;
                    more_nx  = 1'b0;
                    if (pend_stop) begin
                        clr_stop  = 1'b1;
                        data_nx   = CODE_STOP;
                        msg_id_nx = 2'b11;
                    end else if (pend_start) begin
                        clr_start = 1'b1;
                        data_nx   = CODE_START;
                        msg_id_nx = 2'b01;
                    end else begin
                        clr_score = 1'b1;
                        data_nx   = CODE_SCORE;
                        byte1_nx  = score_buf;
                        more_nx   = 1'b1;
                        msg_id_nx = 2'b10;
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT_HI;
                cnt_nx   = '0;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nx = WAIT_LO;
                end else if (cnt == CNT_LAST) begin
                    // no acknowledge: drop the message silently
                    err_nx   = 1'b1;
                    more_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (more) begin
                        state_nx = ISSUE;
                        data_nx  = byte1;
                        more_nx  = 1'b0;
                    end else begin
                        state_nx   = IDLE;
                        sent_nx    = 1'b1;
                        sent_id_nx = msg_id;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // a new request in the grant cycle wins over the clear
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_start <= 1'b0;
            pend_score <= 1'b0;
            pend_stop  <= 1'b0;
            score_buf  <= '0;
            byte1      <= '0;
            more       <= 1'b0;
            msg_id     <= '0;
            cnt        <= '0;
            tx_data    <= '0;
            sent_pulse <= 1'b0;
            sent_id    <= '0;
            tx_err     <= 1'b0;
        end else begin
            pend_start <= req_start | (pend_start & ~clr_start);
            pend_score <= req_score | (pend_score & ~clr_score);
            pend_stop  <= req_stop  | (pend_stop  & ~clr_stop);
            if (req_score) begin
                score_buf <= score_in;
            end
            byte1      <= byte1_nx;
            more       <= more_nx;
            msg_id     <= msg_id_nx;
            cnt        <= cnt_nx;
            tx_data    <= data_nx;
            sent_pulse <= sent_nx;
            sent_id    <= sent_id_nx;
            tx_err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against
// a message-level reference model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int TMO = 4;

    logic       pclk      = 1'b0;
    logic       rst_n     = 1'b1;
    logic       req_start = 1'b0;
    logic       req_score = 1'b0;
    logic       req_stop  = 1'b0;
    logic [7:0] score_in  = 8'h00;
    logic       tx_busy   = 1'b0;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       sent_pulse;
    logic [1:0] sent_id;
    logic       arb_busy;
    logic       tx_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    logic [7:0] wr_log[$];
    logic [1:0] id_log[$];

    always #5 pclk = ~pclk;

    uart_tx_arbiter #(
        .CODE_START (8'h53),
        .CODE_STOP  (8'h45),
        .CODE_SCORE (8'h50),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req_start (req_start),
        .req_score (req_score),
        .score_in  (score_in),
        .req_stop  (req_stop),
        .tx_busy   (tx_busy),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .sent_pulse(sent_pulse),
        .sent_id   (sent_id),
        .arb_busy  (arb_busy),
        .tx_err    (tx_err)
    );

    // transmitter model: busy for tx_len cycles after each accepted write
    int tx_len  = 10;
    bit mute    = 1'b0;
    bit rand_tx = 1'b0;
    int rem     = 0;

    initial begin
        forever begin
            @(negedge pclk);
            if (!rst_n) begin
                rem = 0;
            end else begin
                if (rem > 0) rem--;
                if (tx_wr && !(rand_tx ? ($urandom_range(9, 0) == 0) : mute))
                    rem = rand_tx ? int'($urandom_range(6, 2)) : tx_len;
                else if (rand_tx && rem == 0 && $urandom_range(39, 0) == 0)
                    rem = int'($urandom_range(3, 1));
            end
            tx_busy = (rem > 0);
        end
    end

    // reference model: pending set, byte queue of the message in flight
    bit   [3:1] m_pend   = '0;
    logic [7:0] m_score  = 8'h00;
    logic [7:0] m_q[$];
    int         m_cur    = 0;
    bit         m_active = 1'b0;
    bit         m_acked  = 1'b0;
    int         m_wait   = 0;
    int         pick     = 0;
    bit         nxt_wr   = 1'b0;
    logic       e_wr     = 1'b0;
    logic [7:0] e_data   = 8'h00;
    logic       e_sent   = 1'b0;
    logic [1:0] e_id     = 2'b00;
    logic       e_err    = 1'b0;

    initial begin
        forever begin
            @(posedge pclk or negedge rst_n);
            if (!rst_n) begin
                m_pend = '0; m_score = 8'h00; m_q.delete();
                m_cur = 0; m_active = 0; m_acked = 0; m_wait = 0;
                e_wr = 0; e_data = 8'h00; e_sent = 0; e_id = 2'b00; e_err = 0;
            end else begin
                nxt_wr = 1'b0;
                e_sent = 1'b0;
                if (!m_active) begin
                    if (!tx_busy && m_pend != 0) begin
                        pick = m_pend[3] ? 3 : (m_pend[1] ? 1 : 2);
                        m_pend[pick] = 1'b0;
                        m_q.delete();
                        case (pick)
                            3: m_q.push_back(8'h45);
                            1: m_q.push_back(8'h53);
                            default: begin
                                m_q.push_back(8'h50);
                                m_q.push_back(m_score);
                            end
                        endcase
                        m_cur = pick; m_active = 1'b1;
                        e_data = m_q.pop_front(); nxt_wr = 1'b1;
                    end
                end else if (e_wr) begin
                    m_acked = 1'b0; m_wait = 0;
                end else if (!m_acked) begin
                    if (tx_busy) m_acked = 1'b1;
                    else begin
                        m_wait++;
                        if (m_wait >= TMO) begin
                            e_err = 1'b1; m_active = 1'b0; m_q.delete();
                        end
                    end
                end else if (!tx_busy) begin
                    if (m_q.size() > 0) begin
                        e_data = m_q.pop_front(); nxt_wr = 1'b1;
                    end else begin
                        e_sent = 1'b1; e_id = 2'(m_cur); m_active = 1'b0;
                    end
                end
                if (req_start) m_pend[1] = 1'b1;
                if (req_stop)  m_pend[3] = 1'b1;
                if (req_score) begin m_pend[2] = 1'b1; m_score = score_in; end
                e_wr = nxt_wr;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s: got %h, want %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bytes_sig();
        logic [31:0] v = '0;
        foreach (wr_log[i]) v = {v[23:0], wr_log[i]};
        return v;
    endfunction

    function automatic logic [31:0] ids_sig();
        logic [31:0] v = '0;
        foreach (id_log[i]) v = {v[29:0], id_log[i]};
        return v;
    endfunction

    task automatic pulse(input bit s, input bit c, input bit t, input logic [7:0] v);
        req_start = s; req_score = c; req_stop = t;
        if (c) score_in = v;
        @(negedge pclk);
        req_start = 0; req_score = 0; req_stop = 0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((arb_busy || tx_busy) && k < budget) begin
            @(negedge pclk);
            k++;
        end
        n_cmp++;
        if (arb_busy || tx_busy) begin
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles, want idle", nm, budget);
        end
        repeat (3) @(negedge pclk);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        id_log.delete();
    endtask

    initial begin
        fork
            forever begin
                @(negedge pclk);
                if (check_en) begin
                    chk("tx_wr", tx_wr, e_wr);
                    chk("tx_data", tx_data, e_data);
                    chk("sent_pulse", sent_pulse, e_sent);
                    chk("sent_id", sent_id, e_id);
                    chk("tx_err", tx_err, e_err);
                    chk("arb_busy", arb_busy, m_active || (m_pend != 0));
                    if (tx_wr) wr_log.push_back(tx_data);
                    if (sent_pulse) id_log.push_back(sent_id);
                end
            end
        join_none

        #2 rst_n = 1'b0;
        check_en = 1'b1;
        repeat (2) @(negedge pclk);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_sent_id", sent_id, 0);
        chk("rst_tx_err", tx_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge pclk);

        // single score message, 10-cycle transmitter
        clear_logs();
        pulse(0, 1, 0, 8'h2A);
        chk("lat_wr_early", tx_wr, 0);
        @(negedge pclk);
        chk("lat_wr", tx_wr, 1);
        chk("lat_data", tx_data, 8'h50);
        wait_idle("score_msg", 200);
        chk("score_nbytes", wr_log.size(), 2);
        chk("score_bytes", bytes_sig(), 32'h502A);
        chk("score_ids", ids_sig(), 32'h2);
        chk("score_id_hold", sent_id, 2'b10);

        // all three requests at once
        clear_logs();
        pulse(1, 1, 1, 8'hC3);
        wait_idle("all_three", 400);
        chk("prio_nbytes", wr_log.size(), 4);
        chk("prio_bytes", bytes_sig(), 32'h455350C3);
        chk("prio_ids", ids_sig(), 32'h36);

        // score requests merge while a start message is in flight
        clear_logs();
        pulse(1, 0, 0, 8'h00);
        for (int k = 0; k < 10 && !tx_busy; k++) @(negedge pclk);
        pulse(0, 1, 0, 8'h05);
        repeat (2) @(negedge pclk);
        pulse(0, 1, 0, 8'h07);
        wait_idle("merge", 400);
        chk("merge_nbytes", wr_log.size(), 3);
        chk("merge_bytes", bytes_sig(), 32'h535007);
        chk("merge_ids", ids_sig(), 32'h6);
        chk("merge_no_err", tx_err, 0);

        // transmitter never acknowledges
        clear_logs();
        mute = 1'b1;
        pulse(1, 0, 0, 8'h00);
        wait_idle("timeout", 50);
        chk("tmo_err", tx_err, 1);
        chk("tmo_no_sent", id_log.size(), 0);
        chk("tmo_bytes", bytes_sig(), 32'h53);
        mute = 1'b0;
        clear_logs();
        pulse(0, 0, 1, 8'h00);
        wait_idle("after_tmo", 200);
        chk("after_tmo_bytes", bytes_sig(), 32'h45);
        chk("after_tmo_ids", ids_sig(), 32'h3);
        chk("err_sticky", tx_err, 1);

        // reset while the score header is being shifted
        clear_logs();
        pulse(0, 1, 0, 8'h99);
        for (int k = 0; k < 20 && !tx_busy; k++) @(negedge pclk);
        repeat (3) @(negedge pclk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_wr", tx_wr, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_sent", sent_pulse, 0);
        chk("arst_sent_id", sent_id, 0);
        chk("arst_arb_busy", arb_busy, 0);
        chk("arst_tx_err", tx_err, 0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        clear_logs();
        repeat (20) @(negedge pclk);
        chk("arst_no_resend", wr_log.size(), 0);
        chk("arst_no_sent", id_log.size(), 0);
        chk("arst_idle", arb_busy, 0);

        // randomized traffic with lossy, jittery transmitter
        rand_tx = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req_start = ($urandom_range(11, 0) == 0);
            req_score = ($urandom_range(9, 0) == 0);
            req_stop  = ($urandom_range(13, 0) == 0);
            score_in  = 8'($urandom);
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                #10 rst_n = 1'b1;
            end
            @(negedge pclk);
        end
        req_start = 0; req_score = 0; req_stop = 0;
        rand_tx = 1'b0;
        wait_idle("drain", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CODE_START, default 8'h53, SHALL be the single byte sent for a start message.
REQ-002 Parameter CODE_STOP, default 8'h45, SHALL be the single byte sent for a stop message.
REQ-003 Parameter CODE_SCORE, default 8'h50, SHALL be the header byte of the two-byte score message.
REQ-004 Parameter ACK_TIMEOUT, default 4, SHALL be the maximum cycles to wait for tx_busy to rise after a write.
REQ-005 Port pclk, input, 1: the single clock; all flops SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port req_start, input, 1: one-cycle pulse requesting a start message.
REQ-008 Port req_score, input, 1: one-cycle pulse requesting a score message.
REQ-009 Port score_in, input, 8: score value, sampled on the cycle req_score is high.
REQ-010 Port req_stop, input, 1: one-cycle pulse requesting a stop message.
REQ-011 Port tx_busy, input, 1: high while the UART transmitter shifts a byte.
REQ-012 Port tx_wr, output, 1: one-cycle byte write strobe to the transmitter.
REQ-013 Port tx_data, output, 8: byte to transmit, valid while tx_wr is high.
REQ-014 Port sent_pulse, output, 1: one-cycle pulse on completion of a whole message.
REQ-015 Port sent_id, output, 2: completed message (01 start, 10 score, 11 stop), valid with sent_pulse.
REQ-016 Port arb_busy, output, 1: high when any request is pending or the FSM is not IDLE.
REQ-017 Port tx_err, output, 1: sticky handshake-timeout flag.

Function
REQ-018 A req_* pulse SHALL set its pending flag at that rising edge; repeated pulses while pending SHALL merge into one message.
REQ-019 A req_score pulse SHALL load score_in into the score buffer, overwriting any earlier un-granted value.
REQ-020 Priority SHALL be fixed: stop > start > score.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-022 In IDLE, with any flag pending and tx_busy=0, the FSM SHALL grant the highest-priority flag, clear that flag, copy the byte sequence, and go to ISSUE; with tx_busy=1 it SHALL stay in IDLE.
REQ-023 A request of the same type arriving in the grant cycle SHALL stay pending; set wins over clear.
REQ-024 In ISSUE, tx_wr SHALL be 1 for exactly that cycle with tx_data equal to the current byte; the next state SHALL be WAIT_HI with the timeout counter at 0.
REQ-025 tx_data SHALL hold its last value until the next ISSUE.
REQ-026 In WAIT_HI, tx_busy=1 SHALL move the FSM to WAIT_LO.
REQ-027 In WAIT_HI, after ACK_TIMEOUT cycles without tx_busy, the FSM SHALL set tx_err, drop the message without sent_pulse, and return to IDLE.
REQ-028 In WAIT_LO, when tx_busy=0 and a byte remains, the FSM SHALL go to ISSUE; when no byte remains it SHALL pulse sent_pulse with sent_id and go to IDLE.
REQ-029 A score message SHALL send CODE_SCORE, then the buffered score; start and stop messages SHALL each send one byte.
REQ-030 Latency: with a req sampled at edge k, FSM in IDLE and tx_busy=0, tx_wr SHALL be high between edges k+1 and k+2.
REQ-031 sent_pulse SHALL be high for one cycle, in the cycle after tx_busy falls on the last byte.
REQ-032 sent_id SHALL hold its value until the next sent_pulse.
REQ-033 tx_err SHALL clear only on reset.
REQ-034 The timeout counter SHALL be wide enough for ACK_TIMEOUT and SHALL saturate, not wrap.

Reset
REQ-035 rst_n low SHALL immediately force: FSM IDLE, all pending flags 0, score buffer 0, tx_wr 0, tx_data 0, sent_pulse 0, sent_id 0, arb_busy 0, tx_err 0.
REQ-036 Reset asserted mid-message SHALL abort the message; after release, no part of it SHALL be resent.

Verification
REQ-037 req_score with score_in=8'h2A, transmitter model busy 10 cycles per byte -> tx_wr with 8'h50, then with 8'h2A; sent_pulse with sent_id=10.
REQ-038 req_start, req_score and req_stop all in the same cycle -> bytes sent in order 8'h45, 8'h53, 8'h50, score; three sent_pulses with ids 11, 01, 10.
REQ-039 Two req_score pulses (8'h05, then 8'h07) during a start transmission -> one score message carrying 8'h07.
REQ-040 tx_busy held 0 after tx_wr -> tx_err=1 after ACK_TIMEOUT=4 cycles, no sent_pulse; the next request is still serviced.
REQ-041 rst_n low while in WAIT_LO of a score header -> all outputs 0 at once; after release, idle with no tx_wr.
